// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage operand/destination info in, stall decision out
interface hazard_scoreboard_if #(parameter int REG_AW = 5);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_use;
    logic              id_rs2_use;
    logic              id_use_in_id;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic [1:0]        id_lat_class;
    logic              flush;
    logic              stall;
    logic [1:0]        stall_cause;
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_use_in_id,
               id_rd, id_reg_write, id_lat_class, flush,
        input  stall, stall_cause
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_use_in_id,
               id_rd, id_reg_write, id_lat_class, flush,
        output stall, stall_cause
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register forwarding countdown that stalls ID until operands are reachable
// Optional WAW ordering stall is enabled by defining HAZARD_WAW_CHECK_EN.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int LAT_LOAD = 1,
    parameter int LAT_MUL  = 3,
    parameter int CNT_W    = 3,
    parameter int PERF_W   = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    hazard_scoreboard_if.slave   id,
    output logic [2**REG_AW-1:0] pending,
    output logic [PERF_W-1:0]    stall_cycles
);
    localparam int NREG = 2**REG_AW;

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [CNT_W-1:0] lat1, c1, c2;
    logic             u1, u2, raw_ex, raw_id, waw, issue;

    // Counter value loaded at issue: cycles until the result reaches the forwarding point
    assign lat1 = id.id_lat_class == 2'd0 ? CNT_W'(1) :
                  id.id_lat_class == 2'd1 ? CNT_W'(LAT_LOAD + 1) : CNT_W'(LAT_MUL + 1);

    assign c1 = cnt[id.id_rs1];
    assign c2 = cnt[id.id_rs2];
    assign u1 = id.id_rs1_use & (id.id_rs1 != '0);
    assign u2 = id.id_rs2_use & (id.id_rs2 != '0);

    // EX consumers can catch a value one cycle later than ID consumers
    assign raw_ex = ~id.id_use_in_id & ((u1 & (c1 > CNT_W'(1))) | (u2 & (c2 > CNT_W'(1))));
    assign raw_id =  id.id_use_in_id & ((u1 & (c1 != '0)) | (u2 & (c2 != '0)));

`ifdef HAZARD_WAW_CHECK_EN
    logic [CNT_W-1:0] cd;
    assign cd  = cnt[id.id_rd];
    assign waw = id.id_valid & id.id_reg_write & (id.id_rd != '0) & (cd > lat1);
`else
    assign waw = 1'b0;
`endif

    assign id.stall       = id.id_valid & ~id.flush & (raw_ex | raw_id | waw);
    assign id.stall_cause = ~id.stall ? 2'd0 : raw_id ? 2'd2 : raw_ex ? 2'd1 : 2'd3;
    assign issue          = id.id_valid & ~id.flush & ~id.stall;

    // Next countdown: a fresh issue overrides the decrement; x0 stays at zero
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt[r] = r == 0 ? '0 :
                         (issue & id.id_reg_write & (id.id_rd == REG_AW'(r))) ? lat1 :
                         cnt[r] != '0 ? cnt[r] - CNT_W'(1) : cnt[r];
        end
    end

    // Countdown state, registered pending mirror and saturating stall counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            pending      <= '0;
            stall_cycles <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r]     <= cnt_nxt[r];
                pending[r] <= cnt_nxt[r] != '0;
            end
            if (id.stall && !(&stall_cycles)) stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors for the hazard scoreboard
module tb_hazard_scoreboard;
    localparam int PERF_W = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [31:0]       pending;
    logic [PERF_W-1:0] stall_cycles;
    int                total = 0;
    int                bad = 0;
    logic [PERF_W-1:0] sc0;

    hazard_scoreboard_if #(.REG_AW(5)) bus ();

    hazard_scoreboard #(.PERF_W(PERF_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .id           (bus.slave),
        .pending      (pending),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic uid,
                          input logic [4:0] rd, input logic rw, input logic [1:0] lc,
                          input logic fl);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_rs1_use   = u1;
        bus.id_rs2       = rs2;
        bus.id_rs2_use   = u2;
        bus.id_use_in_id = uid;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_lat_class = lc;
        bus.flush        = fl;
        #1;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Producer with no sources issues on the next edge
    task automatic iss(input logic [4:0] rd, input logic [1:0] lc);
        set_id(1, 0, 0, 0, 0, 0, rd, 1, lc, 0);
        step();
        idle();
    endtask

    // Measure how long the instruction already in ID stalls, then let it issue
    task automatic hold(input string tag, input int exp_len, input int exp_cause);
        int n = 0;
        chk({tag, "_cause"}, 32'(bus.stall_cause), 32'(exp_cause));
        while (bus.stall && n < 16) begin
            step();
            n++;
        end
        chk({tag, "_len"}, 32'(n), 32'(exp_len));
        step();
        idle();
    endtask

    task automatic drain();
        idle();
        repeat (6) step();
    endtask

    initial begin
        idle();
        #1;
        chk("rst_pending", pending, 0);
        chk("rst_stall_cycles", 32'(stall_cycles), 0);
        chk("rst_stall", 32'(bus.stall), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        step();

        // ALU -> branch: 1 cycle, ALU -> EX consumer: none
        iss(5, 0);
        set_id(1, 5, 1, 0, 1, 1, 0, 0, 0, 0);
        hold("alu_br", 1, 2);
        drain();
        iss(5, 0);
        set_id(1, 5, 1, 0, 0, 0, 6, 1, 0, 0);
        hold("alu_ex", 0, 0);
        drain();

        // LOAD -> EX consumer / branch
        iss(7, 1);
        set_id(1, 7, 1, 0, 0, 0, 8, 1, 0, 0);
        hold("ld_ex", 1, 1);
        drain();
        iss(7, 1);
        set_id(1, 7, 1, 0, 0, 1, 1, 1, 0, 0);
        hold("ld_jalr", 2, 2);
        drain();
        iss(7, 1);
        chk("ld_pend_0", 32'(pending[7]), 1);
        step();
        chk("ld_pend_1", 32'(pending[7]), 1);
        step();
        chk("ld_pend_2", 32'(pending[7]), 0);
        drain();

        // MUL -> EX consumer: LAT_MUL cycles
        sc0 = stall_cycles;
        iss(9, 2);
        set_id(1, 0, 1, 9, 1, 0, 10, 1, 0, 0);
        hold("mul_ex", 3, 1);
        chk("mul_sc_delta", 32'(PERF_W'(stall_cycles - sc0)), 3);
        drain();

        // Younger ALU write to a register with a slow multiply in flight
`ifdef HAZARD_WAW_CHECK_EN
        iss(9, 2);
        step();
        set_id(1, 0, 0, 0, 0, 0, 9, 1, 0, 0);
        hold("waw", 2, 3);
`else
        iss(9, 2);
        set_id(1, 0, 0, 0, 0, 0, 9, 1, 0, 0);
        chk("waw_nostall", 32'(bus.stall), 0);
        step();
        idle();
        chk("waw_reload_a", 32'(pending[9]), 1);
        step();
        chk("waw_reload_b", 32'(pending[9]), 0);
`endif
        drain();

        // Flushed dependent branch neither stalls nor loads; x0 never tracked
        iss(7, 1);
        set_id(1, 7, 1, 0, 0, 1, 3, 1, 0, 1);
        chk("flush_stall", 32'(bus.stall), 0);
        chk("flush_cause", 32'(bus.stall_cause), 0);
        step();
        idle();
        chk("flush_noload", 32'(pending[3]), 0);
        iss(0, 2);
        chk("x0_pending", 32'(pending[0]), 0);
        set_id(1, 0, 1, 0, 1, 1, 4, 0, 0, 0);
        chk("x0_src", 32'(bus.stall), 0);
        drain();

        // Asynchronous reset mid-countdown
        iss(7, 1);
        chk("pre_rst_pend", 32'(pending[7]), 1);
        chk("pre_rst_sc_nz", 32'(stall_cycles != 0), 1);
        rstn = 1'b0;
        #1;
        chk("arst_pending", pending, 0);
        chk("arst_sc", 32'(stall_cycles), 0);
        rstn = 1'b1;
        set_id(1, 7, 1, 0, 0, 1, 8, 1, 0, 0);
        chk("post_rst_stall", 32'(bus.stall), 0);
        step();
        drain();

        // MUL -> branch, repeated until the counter saturates
        for (int k = 0; k < 4; k++) begin
            iss(9, 3);
            set_id(1, 9, 1, 0, 0, 1, 0, 0, 0, 0);
            hold("mul_br", 4, 2);
            drain();
            if (k == 2) chk("sc_12", 32'(stall_cycles), 12);
        end
        chk("sc_sat", 32'(stall_cycles), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
